pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage; successor to the plain PC register.
- Adds a configurable reset vector and address width.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so fetch follows predicted-taken branches.
- Execute-stage redirects (mispredict recovery) and branch-resolution updates arrive from EX; pc and its prediction bit go to IF.

Parameters:
- ADDR_WIDTH, 32, width of pc and all address ports.
- RESET_VECTOR, 0, pc value after reset.
- BTB_ENTRIES, 16, number of BTB entries; power of 2, at least 2. IDX_W = log2(BTB_ENTRIES).

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  asynchronous, active-high reset.
- rdy_in  input  1  global enable; when low, all state holds.
- stall_in  input  1  fetch stall; holds pc.
- jump_enable  input  1  EX redirect request.
- jump_target  input  ADDR_WIDTH  redirect address.
- upd_valid  input  1  EX resolved a branch or jump this cycle.
- upd_pc  input  ADDR_WIDTH  address of the resolved instruction.
- upd_taken  input  1  resolved direction.
- upd_target  input  ADDR_WIDTH  resolved target.
- pc  output  ADDR_WIDTH  current fetch address (registered).
- pred_taken  output  1  combinational; 1 when BTB predicts the instruction at pc as taken.
- pred_target  output  ADDR_WIDTH  combinational; BTB target for pc, valid when pred_taken=1, 0 otherwise.

Behaviour:
- Reset (async, rst_in=1): pc=RESET_VECTOR; every BTB valid bit=0; counters=2'b01; targets and tags=0. Consequently pred_taken=0 and pred_target=0 while in reset and immediately after.
- BTB fields:
  - index = pc[IDX_W+1:2].
  - tag = pc[ADDR_WIDTH-1:IDX_W+2].
  - hit = valid[index] && tag match.
  - pred_taken = hit && ctr[index][1].
- Next-pc priority, evaluated at posedge only when rdy_in=1:
  1. jump_enable=1 -> pc<=jump_target. Overrides stall_in.
  2. stall_in=1 -> pc holds.
  3. pred_taken=1 -> pc<=pred_target.
  4. Otherwise pc<=pc+4, modulo 2^ADDR_WIDTH (0xFFFFFFFC wraps to 0).
- pc latency: a redirect is visible on pc one cycle after jump_enable is sampled. jump_target is used as-is; no alignment masking.
- BTB update, at posedge when rdy_in=1 and upd_valid=1, independent of stall_in and jump_enable. Lookup is on upd_pc's index and tag:
  - Tag hit, taken: ctr saturating +1 (max 3); target<=upd_target.
  - Tag hit, not taken: ctr saturating -1 (min 0); target unchanged.
  - Miss, taken: allocate (overwrite) the entry: valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, not taken: no change.
- Same-cycle lookup and update of the same index: the lookup uses pre-update contents; the new contents are visible from the next cycle.
- rdy_in=0: pc, BTB, and counters hold; outputs follow the held state.
- Reset asserted mid-operation clears state immediately, regardless of clock, stall_in or rdy_in.
- Single-cycle: no internal FSM beyond pc and the BTB array; no backpressure outputs.

Test Plan:
- Reset with RESET_VECTOR=0x100; release; 3 cycles, no stall -> pc = 0x100, 0x104, 0x108, 0x10C; pred_taken=0 throughout.
- stall_in=1 at pc=0x10 with jump_enable=1, jump_target=0x200 -> next pc=0x200. Then stall_in=1 alone -> pc holds at 0x200.
- upd_valid, upd_pc=0x40, taken, upd_target=0x80 -> entry allocated with ctr=2. When pc reaches 0x40: pred_taken=1, pred_target=0x80, next pc=0x80.
- Two not-taken updates for 0x40 (ctr 2->1->0) -> pred_taken=0 at pc=0x40; next pc=0x44. One taken update (ctr 1) -> still pc+4. A second taken update (ctr 2) -> predicts taken again.
- Aliasing with BTB_ENTRIES=16: allocate 0x40, then taken update at 0x440 (same index, different tag) -> at pc=0x40 pred_taken=0; at pc=0x440 predicts its target.
- pc=0xFFFFFFFC, no stall -> pc=0. rdy_in=0 for 5 cycles with upd_valid=1 -> pc and BTB unchanged. Assert rst_in between clock edges -> pc=RESET_VECTOR immediately.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program counter with a direct-mapped branch target buffer.
// pc is registered; pred_taken/pred_target are looked up combinationally from pc.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    BTB_ENTRIES  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  stall_in,
  input  logic                  jump_enable,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  logic                  btb_valid  [BTB_ENTRIES];
  logic [1:0]            btb_ctr    [BTB_ENTRIES];
  logic [TAG_W-1:0]      btb_tag    [BTB_ENTRIES];
  logic [ADDR_WIDTH-1:0] btb_target [BTB_ENTRIES];

  logic [IDX_W-1:0]      look_idx;
  logic [TAG_W-1:0]      look_tag;
  logic                  look_hit;
  logic [IDX_W-1:0]      upd_idx;
  logic [TAG_W-1:0]      upd_tag;
  logic                  upd_hit;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic                  unused_upd_lo;

  // Instructions are word aligned, so the low two address bits never index or tag.
  assign look_idx = pc[IDX_W+1:2];
  assign look_tag = pc[ADDR_WIDTH-1:IDX_W+2];
  assign look_hit = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_WIDTH-1:IDX_W+2];
  assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
  assign unused_upd_lo = ^upd_pc[1:0];

  assign pred_taken  = look_hit && btb_ctr[look_idx][1];
  assign pred_target = pred_taken ? btb_target[look_idx] : '0;

  always_comb begin
    pc_next = pc + ADDR_WIDTH'(4);
    if (jump_enable) begin
      pc_next = jump_target;
    end else if (stall_in) begin
      pc_next = pc;
    end else if (pred_taken) begin
      pc_next = pred_target;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pc <= RESET_VECTOR;
    end else if (rdy_in) begin
      pc <= pc_next;
    end
  end

  // Updates write after the lookup of the same cycle, so a same-index update
  // only affects prediction from the following cycle on.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i]  <= 1'b0;
        btb_ctr[i]    <= 2'b01;
        btb_tag[i]    <= '0;
        btb_target[i] <= '0;
      end
    end else if (rdy_in && upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (btb_ctr[upd_idx] != 2'b11) btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'b01;
          btb_target[upd_idx] <= upd_target;
        end else if (btb_ctr[upd_idx] != 2'b00) begin
          btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        btb_valid[upd_idx]  <= 1'b1;
        btb_tag[upd_idx]    <= upd_tag;
        btb_target[upd_idx] <= upd_target;
        btb_ctr[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: expected pc values queued as stimulus is driven,
// popped and compared one cycle later; prediction outputs checked at each pc.
module tb_pc_gen;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        stall_in;
  logic        jump_enable;
  logic [31:0] jump_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  pc_gen #(
    .ADDR_WIDTH  (32),
    .RESET_VECTOR(32'h100),
    .BTB_ENTRIES (16)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .stall_in   (stall_in),
    .jump_enable(jump_enable),
    .jump_target(jump_target),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .pc         (pc),
    .pred_taken (pred_taken),
    .pred_target(pred_target)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    stall_in    = 1'b0;
    jump_enable = 1'b0;
    jump_target = '0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_taken   = 1'b0;
    upd_target  = '0;
  endtask

  // one clock: queue expected pc, advance, compare at the following negedge
  task automatic cycle(input logic [31:0] exp_pc);
    exp_q.push_back(exp_pc);
    @(posedge clk_in);
    @(negedge clk_in);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      check("pc", pc, exp_q.pop_front());
    end
    idle_inputs();
  endtask

  task automatic jump(input logic [31:0] tgt);
    jump_enable = 1'b1;
    jump_target = tgt;
    cycle(tgt);
  endtask

  task automatic update(input logic [31:0] upc, input logic tkn, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = upc;
    upd_taken  = tkn;
    upd_target = tgt;
  endtask

  task automatic check_pred(input string tag, input logic exp_t, input logic [31:0] exp_tgt);
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    check({tag, "_target"}, pred_target, exp_tgt);
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle_inputs();
    @(negedge clk_in);
    @(negedge clk_in);
    check("reset_pc", pc, 32'h100);
    check_pred("reset", 1'b0, 32'h0);
    rst_in = 1'b0;

    // sequential fetch from the reset vector
    cycle(32'h104); check_pred("seq1", 1'b0, 32'h0);
    cycle(32'h108); check_pred("seq2", 1'b0, 32'h0);
    cycle(32'h10C); check_pred("seq3", 1'b0, 32'h0);

    // redirect overrides stall; stall alone holds
    jump(32'h10);
    stall_in = 1'b1;
    jump(32'h200);
    stall_in = 1'b1;
    cycle(32'h200);

    // allocate 0x40 -> 0x80, then follow the prediction
    update(32'h40, 1'b1, 32'h80);
    cycle(32'h204);
    jump(32'h40);
    check_pred("alloc", 1'b1, 32'h80);
    cycle(32'h80);

    // two not-taken: ctr 2 -> 1 -> 0
    update(32'h40, 1'b0, 32'h0);
    cycle(32'h84);
    update(32'h40, 1'b0, 32'h0);
    cycle(32'h88);
    jump(32'h40);
    check_pred("ctr0", 1'b0, 32'h0);
    cycle(32'h44);

    // one taken: ctr 1, still weakly not taken
    update(32'h40, 1'b1, 32'h80);
    cycle(32'h48);
    jump(32'h40);
    check_pred("ctr1", 1'b0, 32'h0);
    cycle(32'h44);

    // second taken: ctr 2, predicts again
    update(32'h40, 1'b1, 32'h80);
    cycle(32'h48);
    jump(32'h40);
    check_pred("ctr2", 1'b1, 32'h80);
    cycle(32'h80);

    // aliasing: 0x440 shares index 0 with 0x40 and evicts it
    update(32'h440, 1'b1, 32'h500);
    cycle(32'h84);
    jump(32'h40);
    check_pred("alias_old", 1'b0, 32'h0);
    cycle(32'h44);
    jump(32'h440);
    check_pred("alias_new", 1'b1, 32'h500);

    // same-cycle lookup and update: prediction uses pre-update counter
    update(32'h440, 1'b0, 32'h0);
    cycle(32'h500);
    jump(32'h440);
    check_pred("post_upd", 1'b0, 32'h0);
    cycle(32'h444);

    // wrap at top of address space
    jump(32'hFFFF_FFFC);
    cycle(32'h0);

    // rdy_in low: everything holds, including the BTB
    for (int i = 0; i < 5; i++) begin
      rdy_in = 1'b0;
      update(32'h0, 1'b1, 32'h900);
      cycle(32'h0);
    end
    rdy_in = 1'b1;
    check_pred("rdy_hold", 1'b0, 32'h0);
    cycle(32'h4);

    // asynchronous reset between edges
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_pc", pc, 32'h100);
    check_pred("async_rst", 1'b0, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    jump(32'h440);
    check_pred("btb_cleared", 1'b0, 32'h0);
    cycle(32'h444);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
